// File: rtl/conv_ddr_rd_responder.sv
// DDR read responder: queues read commands and streams beats from a 1-cycle-latency backing memory.
// Optional feature: define DDR_RD_THROTTLE_EN to limit issue to at most one beat every two cycles.
module conv_ddr_rd_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cmd_adr,
    input  logic [15:0]       cmd_len,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              mem_en,
    output logic [15:0]       mem_adr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_last,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    typedef struct packed {
        logic [15:0] adr;
        logic [15:0] len;
    } cmd_t;

    // The memory only addresses 16 bits of beat space; the upper address bits are ignored.
    logic unused_adr_hi;
    assign unused_adr_hi = ^cmd_adr[31:16];

    cmd_t             fifo_mem [FIFO_DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, empty;

    state_t           state_q, state_d;
    logic [15:0]      adr_q, adr_d, len_q, len_d, idx_q, idx_d;
    logic             rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic             last_beat, issue_ok;

`ifdef DDR_RD_THROTTLE_EN
    logic phase_q, phase_d;

    always_comb phase_d = ~phase_q;

    always_ff @(posedge clk) begin
        if (reset) phase_q <= 1'b1;
        else       phase_q <= phase_d;
    end

    assign issue_ok = phase_q;
`else
    assign issue_ok = 1'b1;
`endif

    assign cmd_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign empty     = (count_q == '0);
    assign head      = fifo_mem[rd_ptr_q];

    // NOTE: queue storage is never reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= '{adr: cmd_adr[15:0], len: cmd_len};
    end

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        pop       = 1'b0;
        mem_en    = 1'b0;
        mem_adr   = '0;
        last_beat = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // The head is issued in the pop cycle itself, giving the t+1 first-issue latency.
                if (!empty) begin
                    if (head.len == '0) begin
                        pop = 1'b1;
                    end else if (issue_ok) begin
                        pop       = 1'b1;
                        mem_en    = 1'b1;
                        mem_adr   = head.adr;
                        last_beat = (head.len == 16'd1);
                        adr_d     = head.adr;
                        len_d     = head.len;
                        idx_d     = 16'd1;
                        if (!last_beat) state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (issue_ok) begin
                    mem_en    = 1'b1;
                    mem_adr   = adr_q + idx_q;
                    last_beat = (idx_q == len_q - 16'd1);
                    idx_d     = idx_q + 16'd1;
                    if (last_beat) begin
                        // Chain straight into the next non-empty command; zero-length ones drain via IDLE.
                        if (!empty && head.len != '0) begin
                            pop   = 1'b1;
                            adr_d = head.adr;
                            len_d = head.len;
                            idx_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d   = push ? ((wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = pop  ? ((rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_valid_d = mem_en;
        rd_last_d  = mem_en && last_beat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            adr_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            adr_q      <= adr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign rd_data_valid = rd_valid_q;
    assign rd_last       = rd_last_q;
    assign rd_data       = rd_valid_q ? mem_rdata : '0;
    assign busy          = !empty || (state_q == S_STREAM) || rd_valid_q;

endmodule

// File: doc/conv_ddr_rd_responder.md
CONV_DDR_RD_RESPONDER -- requirements
Module: conv_ddr_rd_responder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, depth of the command queue (power of two).
REQ-002 Parameter: DATA_W, default 512, width of a data beat.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_adr  input  32  read base address in beat (word) units.
REQ-006 cmd_len  input  16  number of beats to return.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  command queue can accept.
REQ-009 mem_en  output  1  backing-memory read enable.
REQ-010 mem_adr  output  16  backing-memory beat address.
REQ-011 mem_rdata  input  DATA_W  backing-memory data, valid one cycle after mem_en.
REQ-012 rd_data  output  DATA_W  returned beat.
REQ-013 rd_data_valid  output  1  rd_data valid this cycle; no back-pressure exists.
REQ-014 rd_last  output  1  high with the final beat of a command.
REQ-015 busy  output  1  queue non-empty or beat in flight.

Function
REQ-016 A command is accepted in the cycle where cmd_valid and cmd_ready are both high, and is pushed into the FIFO.
REQ-017 cmd_ready = (registered FIFO count < FIFO_DEPTH); a pop in the same cycle does not raise cmd_ready.
REQ-018 States: IDLE, STREAM. IDLE->STREAM when the FIFO is non-empty (pop head, load adr and len). STREAM->IDLE after issuing the last beat when the FIFO is empty. STREAM->STREAM (pop next) after the last beat when the FIFO is non-empty, with no idle cycle.
REQ-019 Commands with cmd_len = 0 are popped and discarded: no mem_en, no rd_data_valid, no rd_last.
REQ-020 In STREAM, each issue cycle: mem_en = 1, mem_adr = cmd_adr[15:0] + beat_idx, with a 16-bit wrap at 0xFFFF -> 0x0000.
REQ-021 rd_data_valid and rd_data (= mem_rdata) follow the corresponding mem_en by exactly 1 cycle; rd_last is registered alongside.
REQ-022 Minimum latency: command accepted at cycle t -> first mem_en at t+1 -> first rd_data_valid at t+2.
REQ-023 Without throttling, beats are issued on consecutive cycles; N beats span N cycles.
REQ-024 When rd_data_valid is 0, rd_data = 0.
REQ-025 busy = FIFO non-empty OR state == STREAM OR rd_data_valid.

Reset
REQ-026 Reset clears the FIFO and sets the state to IDLE, the throttle phase to 1, and all outputs to 0, except cmd_ready, which is 1 in the cycle after reset.
REQ-027 Reset during STREAM abandons the command; rd_data_valid is 0 from the next cycle, and no residual beats or rd_last are produced.

Configuration
REQ-028 Macro DDR_RD_THROTTLE_EN: when defined, a phase bit (reset to 1) toggles every cycle, and mem_en is asserted only when phase = 1, giving at most one beat every 2 cycles. Beat order and rd_last semantics are unchanged.
REQ-029 Without DDR_RD_THROTTLE_EN: no phase logic; beats are issued back-to-back per REQ-023.

Verification
REQ-030 Single command adr=0x100, len=4, memory word[i]=i -> rd_data 0x100..0x103 on 4 consecutive cycles starting 2 cycles after acceptance; rd_last on 0x103 only.
REQ-031 Push 5 commands back-to-back (len=2 each, queue not draining) -> cmd_ready low after the 4th accept; the 5th is accepted after the first pop; all 10 beats in order, with no gap between commands.
REQ-032 Command len=0 followed by adr=0x20, len=1 -> exactly one beat (0x20) with rd_last; the len=0 command produces nothing.
REQ-033 adr=0xFFFE, len=3 -> mem_adr sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-034 Reset asserted after the 2nd beat of len=8 -> no further rd_data_valid; busy=0 and cmd_ready=1 in the cycle after reset.
REQ-035 With DDR_RD_THROTTLE_EN defined, len=4 -> beats 2 cycles apart (7-cycle span), same data and rd_last as REQ-030.
